b08_inv: RTL and testbench
==========================

# b08_inv

Inverse companion to the b08 pattern matcher: given a 4-bit target code, it searches the 8-bit input space for the smallest input vector that the matcher would resolve to exactly that code. It uses the same 8-entry ROM and the same per-entry match rule. It uses the same START-driven handshake, so one bench can drive both blocks back to back. The result is either the candidate vector plus a FOUND flag, or FOUND=0 when no input yields the target.

## Interface
- No parameters. ROM contents are fixed constants.
- CLOCK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request/handshake strobe, same protocol as b08.
- T  input  4  target output code; sampled once per request.
- O  output  8  result input vector; holds its value between requests.
- FOUND  output  1  1 means O produces exactly T; 0 means no 8-bit input produces T.
- BUSY  output  1  high in every state except IDLE.

## Operation
- ROM: 8 entries of 20 bits. Fields are R1=[19:12], R2=[11:4], CODE=[3:0].
  - Entries 0-7, in hex: 7F97A, 39D62, A8FFF, FF6BA, FFF6E, FFBA8, CA75B, 2FFF4.
- Match rule for candidate C against entry k: ((R2 & ~C) | (R1 & C) | (R2 & R1)) == 8'hFF.
  - Per bit, R1R2=11 means don't-care, 10 requires C=1, 01 requires C=0, and 00 never matches.
- RES(C) is the OR of CODE over all matching entries. It is 4'h0 if no entry matches.
- All 8 entries are evaluated combinationally in one cycle, so one candidate is tested per cycle.
- Registers:
  - TGT (4 bits), CAND (8 bits), STATE (2 bits).
  - Output registers O and FOUND.
  - A done-flag register DF holds the search result until it is published.
- States and transitions:
  - IDLE: if START=1, go to INIT; otherwise stay.
  - INIT: TGT<=T, CAND<=0, go to SEARCH.
  - SEARCH:
    - If RES(CAND)==TGT: DF<=1, go to DONE. CAND holds.
    - Else if CAND==8'hFF: DF<=0, go to DONE. CAND holds at FF.
    - Else CAND<=CAND+1 and stay in SEARCH.
  - DONE: if START=0, O<=CAND, FOUND<=DF, go to IDLE. Otherwise wait in DONE with outputs unchanged.
- Search order is ascending from 0x00, so the reported vector is the numerically smallest solution.
- The CAND increment is 8-bit. The FF check precedes the increment, so CAND never wraps to 0x00 within a search.
- T is ignored after INIT. Changing T mid-search has no effect.
- If START is still high when DONE is entered, the block waits in DONE until START falls. It does not restart automatically.
- The START level in SEARCH is ignored. A request can only be aborted by reset.

## Timing
- Reset (RESET=0, asynchronous):
  - STATE=IDLE, TGT=0, CAND=0, DF=0.
  - O=8'h00, FOUND=0, BUSY=0.
- Reset asserted mid-search aborts immediately. O and FOUND return to 0 and no partial result is published.
- BUSY is combinational from STATE: it is 1 in INIT, SEARCH and DONE.
- Let edge E0 be the edge that samples START=1 in IDLE.
  - INIT executes at E1. Candidate n is evaluated at edge E2+n.
  - A solution at candidate n enters DONE at E2+n. O and FOUND update at the first edge at or after E3+n with START=0.
  - No solution: DONE is entered at E257. Outputs update no earlier than E258, with O=8'hFF and FOUND=0.
- O and FOUND change only on the DONE to IDLE edge. They are stable at all other times.

## Test plan
- Reset: hold RESET=0 for 2 cycles mid-search, then release. Required: O=00, FOUND=0, BUSY=0, and a new START is accepted normally.
- T=4'hF, START pulsed 1 cycle. Required: SEARCH lasts 1 cycle (candidate 0x00 matches entries 2 and 7, F|4=F). Then O=8'h00, FOUND=1 at edge E3.
- T=4'h4, START pulsed. Required: 0x00 fails (yields F) and 0x01 matches entry 7 only. Then O=8'h01, FOUND=1 at edge E4.
- T=4'hF with START held high for 10 cycles. Required: the block waits in DONE with BUSY=1 and O/FOUND unchanged, then publishes on the first edge with START=0 and returns to IDLE.
- T=4'h5 issued after a T=4'h4 result, with T toggled during SEARCH. Required: the result is a function of the T sampled in INIT only, and the previous O holds until DONE exits.
- Exhaustive: all 16 targets against a scoreboard that brute-forces RES over 0x00-0xFF. Required:
  - O is the minimal solution, or FF with FOUND=0 when none exists.
  - Cycle count matches 2+n.
  - For every FOUND=1 result, feeding O to b08 yields exactly T.

Source files
------------

// File: rtl/b08_inv_if.sv
// Request/response bundle for the b08 inverse search block.
// The master drives START and T; the slave returns O, FOUND and BUSY.
interface b08_inv_if;
  logic       START;
  logic [3:0] T;
  logic [7:0] O;
  logic       FOUND;
  logic       BUSY;

  modport master (
    output START,
    output T,
    input  O,
    input  FOUND,
    input  BUSY
  );

  modport slave (
    input  START,
    input  T,
    output O,
    output FOUND,
    output BUSY
  );
endinterface

// File: rtl/b08_inv.sv
// Inverse of the b08 matcher: ascending search for the smallest 8-bit vector
// whose ROM match result equals the requested 4-bit target code.
module b08_inv (
  input logic        CLOCK,
  input logic        RESET,
  b08_inv_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INIT   = 2'd1;
  localparam logic [1:0] S_SEARCH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Fixed ROM: R1=[19:12], R2=[11:4], CODE=[3:0].
  function automatic logic [19:0] rom_entry(input logic [2:0] k);
    logic [19:0] e;
    case (k)
      3'd0:    e = 20'h7F97A;
      3'd1:    e = 20'h39D62;
      3'd2:    e = 20'hA8FFF;
      3'd3:    e = 20'hFF6BA;
      3'd4:    e = 20'hFFF6E;
      3'd5:    e = 20'hFFBA8;
      3'd6:    e = 20'hCA75B;
      3'd7:    e = 20'h2FFF4;
      default: e = 20'h00000;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] res_of(input logic [7:0] c);
    logic [3:0]  acc;
    logic [19:0] e;
    acc = 4'h0;
    for (int k = 0; k < 8; k++) begin
      e = rom_entry(3'(k));
      if (((e[11:4] & ~c) | (e[19:12] & c) | (e[11:4] & e[19:12])) == 8'hFF) begin
        acc = acc | e[3:0];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] tgt_q,   tgt_d;
  logic [7:0] cand_q,  cand_d;
  logic       df_q,    df_d;
  logic [7:0] o_q,     o_d;
  logic       found_q, found_d;
  logic [3:0] res_s;

  // Next-state and datapath for the search sequencer.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cand_d  = cand_q;
    df_d    = df_q;
    o_d     = o_q;
    found_d = found_q;
    res_s   = res_of(cand_q);
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        tgt_d   = bus.T;
        cand_d  = 8'h00;
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        // The FF test comes before the increment so CAND never wraps.
        if (res_s == tgt_q) begin
          df_d    = 1'b1;
          state_d = S_DONE;
        end else if (cand_q == 8'hFF) begin
          df_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cand_d  = cand_q + 8'd1;
        end
      end
      S_DONE: begin
        if (!bus.START) begin
          o_d     = cand_q;
          found_d = df_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      tgt_q   <= 4'h0;
      cand_q  <= 8'h00;
      df_q    <= 1'b0;
      o_q     <= 8'h00;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cand_q  <= cand_d;
      df_q    <= df_d;
      o_q     <= o_d;
      found_q <= found_d;
    end
  end

  assign bus.O     = o_q;
  assign bus.FOUND = found_q;
  assign bus.BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_b08_inv.sv
// Directed + randomized bench for b08_inv against a per-bit behavioural model
// of the ROM match rule and a brute-force minimal-solution search.
module tb_b08_inv;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  b08_inv_if bus_if ();

  b08_inv dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] rom_tab [8] = '{20'h7F97A, 20'h39D62, 20'hA8FFF, 20'hFF6BA,
                               20'hFFF6E, 20'hFFBA8, 20'hCA75B, 20'h2FFF4};

  // Per-bit rule: 11 don't care, 10 needs 1, 01 needs 0, 00 never matches.
  function automatic logic [3:0] ref_res(input logic [7:0] c);
    logic [3:0] acc;
    logic [7:0] r1;
    logic [7:0] r2;
    bit         ok;
    acc = 4'h0;
    for (int k = 0; k < 8; k++) begin
      r1 = rom_tab[k][19:12];
      r2 = rom_tab[k][11:4];
      ok = 1'b1;
      for (int b = 0; b < 8; b++) begin
        case ({r1[b], r2[b]})
          2'b11:   ok = ok;
          2'b10:   if (!c[b]) ok = 1'b0;
          2'b01:   if (c[b]) ok = 1'b0;
          default: ok = 1'b0;
        endcase
      end
      if (ok) acc = acc | rom_tab[k][3:0];
    end
    return acc;
  endfunction

  task automatic ref_search(input logic [3:0] t, output int n, output bit fnd);
    n   = 255;
    fnd = 1'b0;
    for (int c = 0; c < 256; c++) begin
      if (!fnd && ref_res(8'(c)) == t) begin
        n   = c;
        fnd = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request from a negedge; START is sampled high on `hold` edges.
  task automatic run_req(input logic [3:0] t, input int hold, input bit toggle, input string tag);
    int         n;
    bit         fnd;
    int         edges;
    int         exp_edges;
    bit         done;
    bit         o_stable;
    logic [7:0] prev_o;
    logic       prev_f;
    ref_search(t, n, fnd);
    exp_edges = (3 + n > hold) ? 3 + n : hold;
    prev_o    = bus_if.O;
    prev_f    = bus_if.FOUND;
    o_stable  = 1'b1;
    done      = 1'b0;
    edges     = -1;
    bus_if.START = 1'b1;
    bus_if.T     = t;
    while (!done && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges + 1 >= hold) bus_if.START = 1'b0;
      if (toggle && edges >= 1) bus_if.T = 4'($urandom);
      if (bus_if.BUSY === 1'b0) begin
        done = 1'b1;
      end else if (bus_if.O !== prev_o || bus_if.FOUND !== prev_f) begin
        o_stable = 1'b0;
      end
    end
    check({tag, ".done"},     32'(done),         32'd1);
    check({tag, ".edges"},    32'(edges),        32'(exp_edges));
    check({tag, ".O"},        32'(bus_if.O),     fnd ? 32'(n) : 32'hFF);
    check({tag, ".FOUND"},    32'(bus_if.FOUND), 32'(fnd));
    check({tag, ".O_stable"}, 32'(o_stable),     32'd1);
    if (fnd) check({tag, ".fwd"}, 32'(ref_res(bus_if.O)), 32'(t));
  endtask

  initial begin
    int         n_long;
    bit         f_long;
    logic [3:0] t_long;
    pass_cnt     = 0;
    total_cnt    = 0;
    rst_n        = 1'b0;
    bus_if.START = 1'b0;
    bus_if.T     = 4'h0;
    repeat (3) @(negedge clk);
    check("rst.O",     32'(bus_if.O),     32'h00);
    check("rst.FOUND", 32'(bus_if.FOUND), 32'd0);
    check("rst.BUSY",  32'(bus_if.BUSY),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Anchor values derived by hand from the ROM.
    check("model.res00", 32'(ref_res(8'h00)), 32'hF);
    check("model.res01", 32'(ref_res(8'h01)), 32'h4);

    run_req(4'hF, 1, 1'b0, "tF");
    run_req(4'h4, 1, 1'b0, "t4");
    run_req(4'h5, 1, 1'b1, "t5_toggle");

    // Abort a long search with reset; no partial result may appear.
    t_long = 4'h1;
    for (int t = 15; t >= 0; t--) begin
      ref_search(4'(t), n_long, f_long);
      if (n_long >= 40) t_long = 4'(t);
    end
    bus_if.START = 1'b1;
    bus_if.T     = t_long;
    @(posedge clk);
    @(negedge clk);
    bus_if.START = 1'b0;
    repeat (20) @(negedge clk);
    check("abort.busy_before", 32'(bus_if.BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.O",     32'(bus_if.O),     32'h00);
    check("abort.FOUND", 32'(bus_if.FOUND), 32'd0);
    check("abort.BUSY",  32'(bus_if.BUSY),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.idle_O",    32'(bus_if.O),    32'h00);
    check("abort.idle_BUSY", 32'(bus_if.BUSY), 32'd0);
    run_req(4'h4, 1, 1'b0, "after_rst");

    run_req(4'hF, 10, 1'b0, "hold10");

    for (int t = 0; t < 16; t++) begin
      run_req(4'(t), int'($urandom_range(1, 4)), 1'($urandom), $sformatf("exh%0d", t));
    end
    for (int i = 0; i < 6; i++) begin
      run_req(4'($urandom), int'($urandom_range(1, 6)), 1'b1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
